// File: rtl/calc_pkg.sv
// Shared definitions for the 4-bit calculator ALU and its scheduler.
package calc_pkg;

  localparam int unsigned W  = 4;  // operand/result width
  localparam int unsigned CW = 2;  // ALU ctrl width

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } state_e;

  // ALU op table shared by the ALU and the scheduler
  localparam logic [CW-1:0] AluAdd = 2'b00;
  localparam logic [CW-1:0] AluSub = 2'b01;
  localparam logic [CW-1:0] AluAnd = 2'b10;
  localparam logic [CW-1:0] AluOr  = 2'b11;

endpackage

// File: rtl/calc_alu_sched_if.sv
// Request, ALU and response bundle for the ALU scheduler.
interface calc_alu_sched_if #(
  parameter int unsigned CNTW = 8
);
  import calc_pkg::*;

  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [2*W-1:0]  req_a;
  logic [2*W-1:0]  req_b;
  logic [2*CW-1:0] req_op;
  logic [W-1:0]    alu_i1;
  logic [W-1:0]    alu_i2;
  logic [CW-1:0]   alu_ctrl;
  logic [W-1:0]    alu_o;
  logic            rsp_valid;
  logic            rsp_ready;
  logic            rsp_id;
  logic [W-1:0]    rsp_data;
  logic [CNTW-1:0] op_count;
  logic            busy;

  // Scheduler side
  modport slave (
    input  req_valid, req_a, req_b, req_op, alu_o, rsp_ready,
    output req_ready, alu_i1, alu_i2, alu_ctrl, rsp_valid, rsp_id, rsp_data, op_count, busy
  );

  // Requesters, ALU and response consumer side
  modport master (
    output req_valid, req_a, req_b, req_op, alu_o, rsp_ready,
    input  req_ready, alu_i1, alu_i2, alu_ctrl, rsp_valid, rsp_id, rsp_data, op_count, busy
  );

endinterface

// File: rtl/rr_arb2.sv
// Combinational 2-way round-robin arbiter; ptr only matters when both request.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic [1:0] gnt_o,
  output logic       gnt_id_o
);

  // Pick the lone requester, or the pointer on contention
  always_comb begin
    gnt_id_o = 1'b0;
    gnt_o    = 2'b00;
    case (req_i)
      2'b01:   gnt_id_o = 1'b0;
      2'b10:   gnt_id_o = 1'b1;
      2'b11:   gnt_id_o = ptr_i;
      default: gnt_id_o = 1'b0;
    endcase
    if (|req_i) gnt_o[gnt_id_o] = 1'b1;
  end

endmodule

// File: rtl/calc_alu_sched.sv
// Shares one calculator ALU between two requesters: IDLE -> EXEC -> RESP.
module calc_alu_sched
  import calc_pkg::*;
#(
  parameter int unsigned CNTW = 8
) (
  input logic              clk,
  input logic              rst,
  calc_alu_sched_if.slave  bus
);

  state_e          state_q, state_d;
  logic            rr_ptr_q, rr_ptr_d;
  logic            grant_q, grant_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [CW-1:0]   op_q, op_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_id_q, rsp_id_d;
  logic [W-1:0]    rsp_data_q, rsp_data_d;
  logic [CNTW-1:0] op_count_q, op_count_d;
  // High for the single cycle after reset, keeps req_ready low there
  logic            blank_q;

  logic [1:0] gnt;
  logic       gnt_id;
  logic       req_hs;

  rr_arb2 u_arb (
    .req_i    (bus.req_valid),
    .ptr_i    (rr_ptr_q),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id)
  );

  assign bus.req_ready = (state_q == StIdle && !blank_q) ? gnt : 2'b00;
  assign req_hs        = |(bus.req_valid & bus.req_ready);

  assign bus.alu_i1    = a_q;
  assign bus.alu_i2    = b_q;
  assign bus.alu_ctrl  = op_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.op_count  = op_count_q;
  assign bus.busy      = (state_q != StIdle);

  // Next-state: accept, execute one cycle, then hold the response until taken
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    op_count_d  = op_count_q;
    unique case (state_q)
      StIdle: begin
        if (req_hs) begin
          a_d     = gnt_id ? bus.req_a[2*W-1:W]    : bus.req_a[W-1:0];
          b_d     = gnt_id ? bus.req_b[2*W-1:W]    : bus.req_b[W-1:0];
          op_d    = gnt_id ? bus.req_op[2*CW-1:CW] : bus.req_op[CW-1:0];
          grant_d = gnt_id;
          state_d = StExec;
        end
      end
      StExec: begin
        rsp_data_d  = bus.alu_o;
        rsp_id_d    = grant_q;
        rsp_valid_d = 1'b1;
        state_d     = StResp;
      end
      StResp: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          op_count_d  = op_count_q + 1'b1;
          rr_ptr_d    = ~grant_q;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset; operands are not cleared between ops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      rr_ptr_q    <= 1'b0;
      grant_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      op_count_q  <= '0;
      blank_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      op_count_q  <= op_count_d;
      blank_q     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_calc_alu_sched.sv
// Directed bench for calc_alu_sched with a stub ALU.
module tb_calc_alu_sched;
  import calc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  calc_alu_sched_if #(.CNTW(8)) bus ();

  calc_alu_sched #(.CNTW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Stub ALU
  always_comb begin
    bus.alu_o = '0;
    case (bus.alu_ctrl)
      AluAdd:  bus.alu_o = bus.alu_i1 + bus.alu_i2;
      AluSub:  bus.alu_o = bus.alu_i1 - bus.alu_i2;
      AluAnd:  bus.alu_o = bus.alu_i1 & bus.alu_i2;
      default: bus.alu_o = bus.alu_i1 | bus.alu_i2;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Returns with the current sample showing rsp_valid, or ok=0 after the budget
  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus.rsp_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  initial begin
    bit        ok;
    bit        seen;
    logic [3:0] exp_d2 [2];
    logic       exp_i2 [2];

    bus.req_valid = 2'b00;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = '0;
    bus.rsp_ready = 1'b1;

    // 1. Reset state and single request
    do_reset();
    check("rst_busy", bus.busy, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_id", bus.rsp_id, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_op_count", bus.op_count, 0);
    check("rst_alu_i1", bus.alu_i1, 0);
    check("rst_alu_i2", bus.alu_i2, 0);
    check("rst_alu_ctrl", bus.alu_ctrl, 0);
    bus.req_a     = {4'd0, 4'd6};
    bus.req_b     = {4'd0, 4'd2};
    bus.req_op    = {2'b00, AluAdd};
    bus.req_valid = 2'b01;
    check("rst_req_ready", bus.req_ready, 0);
    tick();
    check("t1_req_ready", bus.req_ready, 2'b01);
    tick();
    check("t1_exec_busy", bus.busy, 1);
    check("t1_exec_i1", bus.alu_i1, 6);
    check("t1_exec_i2", bus.alu_i2, 2);
    check("t1_exec_ctrl", bus.alu_ctrl, 0);
    check("t1_exec_valid", bus.rsp_valid, 0);
    check("t1_exec_ready", bus.req_ready, 0);
    bus.req_valid = 2'b00;
    tick();
    check("t1_rsp_valid", bus.rsp_valid, 1);
    check("t1_rsp_data", bus.rsp_data, 8);
    check("t1_rsp_id", bus.rsp_id, 0);
    tick();
    check("t1_done_valid", bus.rsp_valid, 0);
    check("t1_op_count", bus.op_count, 1);
    check("t1_done_busy", bus.busy, 0);

    // 2. Both valid after reset: requester 0 first
    do_reset();
    exp_d2[0] = 4'd4;
    exp_i2[0] = 1'b0;
    exp_d2[1] = 4'd2;
    exp_i2[1] = 1'b1;
    bus.req_a     = {4'd6, 4'd6};
    bus.req_b     = {4'd2, 4'd2};
    bus.req_op    = {AluAnd, AluSub};
    bus.req_valid = 2'b11;
    for (int r = 0; r < 2; r++) begin
      wait_rsp(ok);
      check("t2_rsp_seen", ok, 1);
      check("t2_rsp_id", bus.rsp_id, exp_i2[r]);
      check("t2_rsp_data", bus.rsp_data, exp_d2[r]);
      tick();
    end
    bus.req_valid = 2'b00;

    // 3. Backpressure with a lone requester 1
    do_reset();
    bus.req_a     = {4'd3, 4'd0};
    bus.req_b     = {4'd4, 4'd0};
    bus.req_op    = {AluSub, AluAdd};
    bus.req_valid = 2'b10;
    bus.rsp_ready = 1'b0;
    wait_rsp(ok);
    check("t3_rsp_seen", ok, 1);
    bus.req_valid = 2'b11;
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_valid", bus.rsp_valid, 1);
      check("t3_hold_data", bus.rsp_data, 15);
      check("t3_hold_id", bus.rsp_id, 1);
      check("t3_hold_ready", bus.req_ready, 0);
      check("t3_hold_busy", bus.busy, 1);
      tick();
    end
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b1;
    tick();
    check("t3_rel_valid", bus.rsp_valid, 0);
    check("t3_rel_count", bus.op_count, 1);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.rsp_valid) seen = 1'b1;
    end
    check("t3_single_rsp", seen, 0);
    check("t3_final_count", bus.op_count, 1);

    // 4. Fairness over six back-to-back ops
    do_reset();
    bus.req_a     = {4'd9, 4'd6};
    bus.req_b     = {4'd5, 4'd2};
    bus.req_op    = {AluAdd, AluOr};
    bus.req_valid = 2'b11;
    for (int r = 0; r < 6; r++) begin
      wait_rsp(ok);
      check("t4_rsp_seen", ok, 1);
      check("t4_rsp_id", bus.rsp_id, r % 2);
      check("t4_rsp_data", bus.rsp_data, (r % 2 == 0) ? 6 : 14);
      tick();
    end
    bus.req_valid = 2'b00;
    check("t4_op_count", bus.op_count, 6);

    // 5. Reset during EXEC abandons the op
    bus.req_a     = {4'd0, 4'd6};
    bus.req_b     = {4'd0, 4'd2};
    bus.req_op    = {2'b00, AluAdd};
    bus.req_valid = 2'b01;
    tick();
    check("t5_in_exec", bus.busy, 1);
    bus.req_valid = 2'b00;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_rsp_valid", bus.rsp_valid, 0);
    check("t5_busy", bus.busy, 0);
    check("t5_op_count", bus.op_count, 0);
    check("t5_alu_i1", bus.alu_i1, 0);
    check("t5_alu_i2", bus.alu_i2, 0);
    check("t5_alu_ctrl", bus.alu_ctrl, 0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bus.rsp_valid) seen = 1'b1;
      tick();
    end
    check("t5_no_rsp", seen, 0);

    // 6. Counter wrap over 256 ops, sub wraps mod 16
    do_reset();
    bus.req_a     = {4'd0, 4'd2};
    bus.req_b     = {4'd0, 4'd6};
    bus.req_op    = {2'b00, AluSub};
    bus.req_valid = 2'b01;
    for (int n = 1; n <= 256; n++) begin
      wait_rsp(ok);
      if (!ok) begin
        check("t6_timeout", ok, 1);
        break;
      end
      if (n == 1 || n == 256) begin
        check("t6_rsp_data", bus.rsp_data, 12);
        check("t6_rsp_id", bus.rsp_id, 0);
      end
      tick();
      if (n == 255) check("t6_count_255", bus.op_count, 255);
      if (n == 256) begin
        bus.req_valid = 2'b00;
        check("t6_count_wrap", bus.op_count, 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
